// File: rtl/esp_uart_pkg.sv
// Shared types and constants for the ESP32 UART: FSM state encodings,
// break framing constants and the RX majority-vote helper.
package esp_uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_BREAK,
    TX_BRK_IDLE
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  localparam int         BREAK_BITS = 20;
  localparam logic [8:0] UART_BREAK = 9'h100;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/esp_uart_fifo.sv
// Circular first-word-fall-through FIFO with (AW+1)-bit pointers; reads
// zero while empty, ignores push-when-full and pop-when-empty.
module esp_uart_fifo #(
  parameter int WIDTH = 9,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      free
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      wptr, rptr, count;
  logic             do_wr, do_rd;

  assign count = wptr - rptr;
  assign full  = count[AW];
  assign empty = (wptr == rptr);
  assign free  = DEPTH - count;
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  // NOTE: storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wdata;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + (AW+1)'(1);
      if (do_rd) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/esp_uart.sv
// Full-duplex 8N1 UART to the ESP32 with 9-bit break-extended FIFO entries.
// Optional CTS/RTS hardware flow control: define ESP_UART_HWFLOW_EN.
module esp_uart
  import esp_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 14,
  parameter int FIFO_AW    = 7,
  parameter int RTS_MARGIN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic       uart_cts_n,
  output logic       uart_rts_n,
  input  logic [8:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_fifo_full,
  output logic [8:0] rx_data,
  input  logic       rx_rd,
  output logic       rx_empty,
  output logic       rx_fifo_overflow,
  output logic       rx_framing_error
);

  localparam int           CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_BIT  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(BAUD_DIV / 2 - 1);
  localparam logic [4:0]    LAST_DATA = 5'd7;
  localparam logic [4:0]    LAST_BRK  = 5'(BREAK_BITS - 1);

  logic [8:0]     txf_rdata;
  logic           txf_empty, tx_pop, tx_go;
  logic [FIFO_AW:0] txf_free, rxf_free;
  logic           rxf_full, rx_push;
  logic [8:0]     rx_push_data;

  esp_uart_fifo #(.WIDTH(9), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .reset(reset), .wr(tx_wr), .wdata(tx_data), .rd(tx_pop),
    .rdata(txf_rdata), .full(tx_fifo_full), .empty(txf_empty), .free(txf_free)
  );

  esp_uart_fifo #(.WIDTH(9), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .reset(reset), .wr(rx_push), .wdata(rx_push_data), .rd(rx_rd),
    .rdata(rx_data), .full(rxf_full), .empty(rx_empty), .free(rxf_free)
  );

`ifdef ESP_UART_HWFLOW_EN
  localparam logic [FIFO_AW:0] RTS_FREE = (FIFO_AW+1)'(RTS_MARGIN);
  logic [1:0] cts_sync;
  logic       unused_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cts_sync <= 2'b11;
    else       cts_sync <= {cts_sync[0], uart_cts_n};
  end

  assign tx_go      = !txf_empty && !cts_sync[1];
  assign uart_rts_n = (rxf_free < RTS_FREE);
  assign unused_ok  = ^txf_free;
`else
  logic unused_ok;
  assign tx_go      = !txf_empty;
  assign uart_rts_n = 1'b0;
  assign unused_ok  = ^{txf_free, rxf_free, uart_cts_n};
`endif

  // ---------------- transmitter ----------------
  tx_state_t     tx_state, tx_state_next;
  logic [CW-1:0] tx_cnt;
  logic [4:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_bit_done;

  assign tx_bit_done = (tx_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= FULL_BIT;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_next;
      if (tx_state_next != tx_state || tx_bit_done) tx_cnt <= FULL_BIT;
      else                                          tx_cnt <= tx_cnt - CW'(1);
      if (tx_state_next != tx_state) tx_idx <= '0;
      else if (tx_bit_done)          tx_idx <= tx_idx + 5'd1;
      if (tx_pop)                                  tx_shift <= txf_rdata[7:0];
      else if (tx_state == TX_DATA && tx_bit_done) tx_shift <= {1'b0, tx_shift[7:1]};
    end
  end

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    tx_state_next = tx_state;
    tx_pop        = 1'b0;
    case (tx_state)
      TX_IDLE: if (tx_go) begin
        tx_pop        = 1'b1;
        tx_state_next = txf_rdata[8] ? TX_BREAK : TX_START;
      end
      TX_START: if (tx_bit_done) tx_state_next = TX_DATA;
      TX_DATA:  if (tx_bit_done && tx_idx == LAST_DATA) tx_state_next = TX_STOP;
      TX_BREAK: if (tx_bit_done && tx_idx == LAST_BRK)  tx_state_next = TX_BRK_IDLE;
      TX_STOP, TX_BRK_IDLE: if (tx_bit_done) begin
        // Chain straight into the next entry so frames run without a gap.
        if (tx_go) begin
          tx_pop        = 1'b1;
          tx_state_next = txf_rdata[8] ? TX_BREAK : TX_START;
        end else begin
          tx_state_next = TX_IDLE;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    uart_txd = 1'b1;
    case (tx_state)
      TX_START, TX_BREAK: uart_txd = 1'b0;
      TX_DATA:            uart_txd = tx_shift[0];
      default:            uart_txd = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_t     rx_state, rx_state_next;
  logic [CW-1:0] rx_cnt;
  logic [4:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic [1:0]    rxd_sync;
  logic [2:0]    rx_hist;
  logic          rx_filt, rx_prev, rx_fall, rx_bit_done, rx_ferr_set;

  assign rx_bit_done = (rx_cnt == '0);
  assign rx_fall     = rx_prev && !rx_filt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_sync         <= 2'b11;
      rx_hist          <= 3'b111;
      rx_filt          <= 1'b1;
      rx_prev          <= 1'b1;
      rx_state         <= RX_IDLE;
      rx_cnt           <= FULL_BIT;
      rx_idx           <= '0;
      rx_shift         <= '0;
      rx_fifo_overflow <= 1'b0;
      rx_framing_error <= 1'b0;
    end else begin
      rxd_sync <= {rxd_sync[0], uart_rxd};
      rx_hist  <= {rx_hist[1:0], rxd_sync[1]};
      rx_filt  <= maj3(rx_hist);
      rx_prev  <= rx_filt;
      rx_state <= rx_state_next;
      if (rx_state_next != rx_state) rx_cnt <= (rx_state_next == RX_START) ? HALF_BIT : FULL_BIT;
      else if (rx_bit_done)          rx_cnt <= FULL_BIT;
      else                           rx_cnt <= rx_cnt - CW'(1);
      if (rx_state_next != rx_state) rx_idx <= '0;
      else if (rx_bit_done)          rx_idx <= rx_idx + 5'd1;
      if (rx_state == RX_DATA && rx_bit_done) rx_shift <= {rx_filt, rx_shift[7:1]};
      rx_fifo_overflow <= rx_push && rxf_full;
      rx_framing_error <= rx_ferr_set;
    end
  end

  always_comb begin
    rx_state_next = rx_state;
    rx_push       = 1'b0;
    rx_push_data  = UART_BREAK;
    rx_ferr_set   = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_next = RX_START;
      RX_START: if (rx_bit_done) rx_state_next = rx_filt ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_done && rx_idx == LAST_DATA) rx_state_next = RX_STOP;
      RX_STOP: if (rx_bit_done) begin
        if (rx_filt) begin
          rx_push       = 1'b1;
          rx_push_data  = {1'b0, rx_shift};
          rx_state_next = RX_IDLE;
        end else if (rx_shift == 8'h00) begin
          // An all-zero frame with a low stop bit is the ESP's break marker.
          rx_push       = 1'b1;
          rx_state_next = RX_WAIT_HIGH;
        end else begin
          rx_ferr_set   = 1'b1;
          rx_state_next = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: if (rx_filt) rx_state_next = RX_IDLE;
      default: rx_state_next = RX_IDLE;
    endcase
  end

endmodule
